// File: rtl/serial_bit_receiver_if.sv
// serial_bit_receiver_if
//   Bundles the serial line input and the recovered-bit / status outputs
//   of serial_bit_receiver.
//   master : receiver side (samples i_rx, drives every o_* signal)
//   slave  : line driver / consumer side (drives i_rx, observes o_*)
//   Signals:
//     i_rx         asynchronous serial line, idles high
//     o_bit        recovered data bit, qualified by o_bit_valid
//     o_bit_valid  one-cycle strobe per recovered data bit
//     o_frame_err  one-cycle strobe when a stop bit samples 0
//     o_busy       high whenever the receiver is not idle
//     o_frame_cnt  saturating count of good frames
//     o_err_cnt    saturating count of framing errors
interface serial_bit_receiver_if;
  logic       i_rx;
  logic       o_bit;
  logic       o_bit_valid;
  logic       o_frame_err;
  logic       o_busy;
  logic [7:0] o_frame_cnt;
  logic [7:0] o_err_cnt;

  modport master (
    input  i_rx,
    output o_bit,
    output o_bit_valid,
    output o_frame_err,
    output o_busy,
    output o_frame_cnt,
    output o_err_cnt
  );

  modport slave (
    output i_rx,
    input  o_bit,
    input  o_bit_valid,
    input  o_frame_err,
    input  o_busy,
    input  o_frame_cnt,
    input  o_err_cnt
  );
endinterface

// File: rtl/serial_bit_receiver.sv
// serial_bit_receiver
//   Recovers start / DATA_BITS (MSB first) / stop framed serial data from an
//   asynchronous idle-high line. Each data bit is emitted as a one-cycle
//   o_bit_valid strobe with o_bit, suitable for the vector buffer write side.
//   Framing errors pulse o_frame_err; good frames and errors are counted in
//   saturating 8-bit counters.
//   Ports:
//     i_clk  system clock, all state on posedge
//     i_rst  synchronous active-high reset
//     bus    serial_bit_receiver_if.master (i_rx in, o_* out)
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//     DATA_BITS     data bits per frame
module serial_bit_receiver #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  serial_bit_receiver_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_BREAK,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             w_rx;
  logic             r_rx_meta;
  logic             r_rx_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_bit;
  logic             r_bit_valid;
  logic             r_frame_err;
  logic             r_busy;
  logic [7:0]       r_frame_cnt;
  logic [7:0]       r_err_cnt;

  assign w_rx = bus.i_rx;

  // Two-flop synchronizer; reset to the idle level so reset never looks
  // like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= w_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_BREAK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b1;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_bit_valid <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        // Hold off until the line is seen idle, so we never lock onto
        // the middle of a frame after reset or a framing error.
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= '0;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit to reject glitches.
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            if (!r_rx_s) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Counting a full bit from mid start lands on mid data bit.
        S_DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_bit       <= r_rx_s;
            r_bit_valid <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= r_idx + IDX_W'(1);
            if (r_idx == IDX_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              if (r_frame_cnt != 8'hFF) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_BREAK;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_bit       = r_bit;
  assign bus.o_bit_valid = r_bit_valid;
  assign bus.o_frame_err = r_frame_err;
  assign bus.o_busy      = r_busy;
  assign bus.o_frame_cnt = r_frame_cnt;
  assign bus.o_err_cnt   = r_err_cnt;

endmodule
